// File: rtl/instr_exec_reader_if.sv
// Bundles the run-control, instruction-read and result channels of instr_exec_reader.
// The master modport is the driver/bench side and the slave modport is the reader.
interface instr_exec_reader_if #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int CNT_W  = 6
) ();
  logic                     start;
  logic [ADDR_W-1:0]        first_addr;
  logic [CNT_W-1:0]         count;
  logic [ADDR_W-1:0]        read_pointer;
  logic [3:0]               rd_opcode;
  logic signed [OP_W-1:0]   rd_operand_a;
  logic signed [OP_W-1:0]   rd_operand_b;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [2*OP_W-1:0] res_data;
  logic [3:0]               res_opcode;
  logic [ADDR_W-1:0]        res_addr;
  logic                     res_err;
  logic                     busy;
  logic                     done;

  modport master (
    output start, first_addr, count, rd_opcode, rd_operand_a, rd_operand_b, res_ready,
    input  read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
  );

  modport slave (
    input  start, first_addr, count, rd_opcode, rd_operand_a, rd_operand_b, res_ready,
    output read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
  );
endinterface

// File: rtl/instr_exec_reader.sv
// Walks read_pointer over a range of the instruction register, executes each entry
// and offers one result per instruction on a valid/ready channel.
module instr_exec_reader #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int CNT_W  = 6
) (
  input logic               clk,
  input logic               reset,
  instr_exec_reader_if.slave bus
);
  localparam int RES_W = 2 * OP_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_W-1:0]       r_ptr, r_addr, r_res_addr;
  logic [CNT_W-1:0]        r_remaining;
  logic [3:0]              r_op, r_res_opcode;
  logic signed [OP_W-1:0]  r_a, r_b;
  logic signed [RES_W-1:0] r_res_data, w_exec_data, w_a_ext, w_b_ext;
  logic                    r_res_valid, r_res_err, r_done, w_exec_err;
  logic                    w_start_run, w_start_empty, w_accept, w_last;

  assign w_start_run   = (r_state == S_IDLE) && bus.start && (bus.count != '0);
  assign w_start_empty = (r_state == S_IDLE) && bus.start && (bus.count == '0);
  assign w_accept      = (r_state == S_OUT) && r_res_valid && bus.res_ready;
  assign w_last        = (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_OUT;
      S_OUT:   if (w_accept) w_state_next = w_last ? S_IDLE : S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operands are widened before every operation so MULT keeps the full product
  // and the single overflowing DIV case (min / -1) stays representable.
  assign w_a_ext = {{OP_W{r_a[OP_W-1]}}, r_a};
  assign w_b_ext = {{OP_W{r_b[OP_W-1]}}, r_b};

  always_comb begin
    w_exec_data = '0;
    w_exec_err  = 1'b0;
    case (r_op)
      4'd0: w_exec_data = '0;
      4'd1: w_exec_data = w_a_ext;
      4'd2: w_exec_data = w_b_ext;
      4'd3: w_exec_data = w_a_ext + w_b_ext;
      4'd4: w_exec_data = w_a_ext - w_b_ext;
      4'd5: w_exec_data = w_a_ext * w_b_ext;
      4'd6: begin
        if (r_b == '0) w_exec_err = 1'b1;
        else           w_exec_data = w_a_ext / w_b_ext;
      end
      4'd7: begin
        if (r_b == '0) w_exec_err = 1'b1;
        else           w_exec_data = w_a_ext % w_b_ext;
      end
      default: w_exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_addr       <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= '0;
      r_res_addr   <= '0;
      r_res_err    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_run) begin
            r_ptr       <= bus.first_addr;
            r_remaining <= bus.count;
          end else if (w_start_empty) begin
            r_done <= 1'b1;
          end
        end
        S_FETCH: begin
          r_op   <= bus.rd_opcode;
          r_a    <= bus.rd_operand_a;
          r_b    <= bus.rd_operand_b;
          r_addr <= r_ptr;
        end
        S_EXEC: begin
          r_res_data   <= w_exec_data;
          r_res_err    <= w_exec_err;
          r_res_opcode <= r_op;
          r_res_addr   <= r_addr;
          r_res_valid  <= 1'b1;
        end
        S_OUT: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_last) r_done <= 1'b1;
            else        r_ptr  <= r_ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.read_pointer = r_ptr;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_opcode   = r_res_opcode;
  assign bus.res_addr     = r_res_addr;
  assign bus.res_err      = r_res_err;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;
endmodule

// File: tb/tb_instr_exec_reader.sv
// Directed bench for instr_exec_reader: a small instruction memory feeds the read
// port and each scenario task compares outputs against hand-computed values.
module tb_instr_exec_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0]         mem_op [32];
  logic signed [31:0] mem_a  [32];
  logic signed [31:0] mem_b  [32];

  instr_exec_reader_if #(.ADDR_W(5), .OP_W(32), .CNT_W(6)) bus ();

  instr_exec_reader #(.ADDR_W(5), .OP_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rd_opcode    = mem_op[bus.read_pointer];
  assign bus.rd_operand_a = mem_a[bus.read_pointer];
  assign bus.rd_operand_b = mem_b[bus.read_pointer];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int addr, input logic [3:0] op,
                           input logic signed [31:0] a, input logic signed [31:0] b);
    mem_op[addr] = op;
    mem_a[addr]  = a;
    mem_b[addr]  = b;
  endtask

  // Bounded wait for res_valid; lat is the number of edges taken, -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        lat = i;
        $display("txn addr=%0d op=%0d data=%0d err=%0b",
                 bus.res_addr, bus.res_opcode, bus.res_data, bus.res_err);
        break;
      end
    end
  endtask

  task automatic start_run(input logic [4:0] addr, input logic [5:0] cnt);
    bus.start      = 1'b1;
    bus.first_addr = addr;
    bus.count      = cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.res_valid); end
    n_vec++; if (bus.read_pointer !== 5'd0) begin n_err++; $display("FAIL reset_ptr got=%0d exp=0", bus.read_pointer); end
    n_vec++; if (bus.res_data !== 64'sd0) begin n_err++; $display("FAIL reset_data got=%0d exp=0", bus.res_data); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got=%0b%0b exp=00", bus.busy, bus.done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_single();
    int lat;
    set_entry(3, 4'd3, 7, -10);
    bus.res_ready = 1'b1;
    start_run(5'd3, 6'd1);
    wait_valid(lat);
    bus.start = 1'b0;
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL add_latency got=%0d exp=3", lat); end
    n_vec++; if (bus.res_data !== -64'sd3) begin n_err++; $display("FAIL add_data got=%0d exp=-3", bus.res_data); end
    n_vec++; if (bus.res_addr !== 5'd3 || bus.res_err !== 1'b0 || bus.res_opcode !== 4'd3) begin
      n_err++; $display("FAIL add_fields got addr=%0d err=%0b op=%0d exp addr=3 err=0 op=3", bus.res_addr, bus.res_err, bus.res_opcode); end
    tick();
    n_vec++; if (bus.done !== 1'b1 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL add_done got done=%0b valid=%0b exp 1 0", bus.done, bus.res_valid); end
    tick();
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got done=%0b busy=%0b exp 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_wrap_arith();
    int lat;
    logic signed [63:0] exp_data [3];
    logic [4:0]         exp_addr [3];
    exp_data[0] = -64'sd4294967296; exp_addr[0] = 5'd30;
    exp_data[1] = -64'sd3;          exp_addr[1] = 5'd31;
    exp_data[2] = -64'sd1;          exp_addr[2] = 5'd0;
    set_entry(30, 4'd5, -65536, 65536);
    set_entry(31, 4'd6, -7, 2);
    set_entry(0,  4'd7, -7, 2);
    bus.res_ready = 1'b1;
    start_run(5'd30, 6'd3);
    for (int k = 0; k < 3; k++) begin
      wait_valid(lat);
      bus.start = 1'b0;
      n_vec++; if (lat !== (k == 0 ? 3 : 2)) begin n_err++; $display("FAIL wrap_lat%0d got=%0d exp=%0d", k, lat, (k == 0 ? 3 : 2)); end
      n_vec++; if (bus.res_data !== exp_data[k]) begin n_err++; $display("FAIL wrap_data%0d got=%0d exp=%0d", k, bus.res_data, exp_data[k]); end
      n_vec++; if (bus.res_addr !== exp_addr[k] || bus.res_err !== 1'b0) begin
        n_err++; $display("FAIL wrap_addr%0d got addr=%0d err=%0b exp addr=%0d err=0", k, bus.res_addr, bus.res_err, exp_addr[k]); end
      tick();
    end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%0b exp=1", bus.done); end
    tick();
  endtask

  task automatic test_errors();
    int lat;
    logic signed [63:0] exp_data [3];
    logic [3:0]         exp_op   [3];
    logic               exp_err  [3];
    exp_data[0] = 64'sd0;          exp_op[0] = 4'd6;  exp_err[0] = 1'b1;
    exp_data[1] = 64'sd0;          exp_op[1] = 4'd12; exp_err[1] = 1'b1;
    exp_data[2] = 64'sd2147483648; exp_op[2] = 4'd6;  exp_err[2] = 1'b0;
    set_entry(5, 4'd6, 9, 0);
    set_entry(6, 4'd12, 5, 3);
    set_entry(7, 4'd6, 32'sh80000000, -1);
    bus.res_ready = 1'b1;
    start_run(5'd5, 6'd3);
    for (int k = 0; k < 3; k++) begin
      wait_valid(lat);
      bus.start = 1'b0;
      n_vec++; if (lat < 0) begin n_err++; $display("FAIL err_timeout%0d got=%0d exp>0", k, lat); end
      n_vec++; if (bus.res_data !== exp_data[k] || bus.res_err !== exp_err[k] || bus.res_opcode !== exp_op[k]) begin
        n_err++; $display("FAIL err_res%0d got data=%0d err=%0b op=%0d exp data=%0d err=%0b op=%0d",
                          k, bus.res_data, bus.res_err, bus.res_opcode, exp_data[k], exp_err[k], exp_op[k]); end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    set_entry(10, 4'd4, 100, 30);
    set_entry(11, 4'd3, 1, 1);
    bus.res_ready = 1'b0;
    start_run(5'd10, 6'd2);
    wait_valid(lat);
    bus.start = 1'b0;
    n_vec++; if (bus.res_data !== 64'sd70) begin n_err++; $display("FAIL bp_first got=%0d exp=70", bus.res_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== 64'sd70 || bus.read_pointer !== 5'd10) begin
        n_err++; $display("FAIL bp_hold%0d got valid=%0b data=%0d ptr=%0d exp 1 70 10", i, bus.res_valid, bus.res_data, bus.read_pointer); end
    end
    bus.res_ready = 1'b1;
    tick();
    n_vec++; if (bus.res_valid !== 1'b0 || bus.read_pointer !== 5'd11) begin
      n_err++; $display("FAIL bp_accept got valid=%0b ptr=%0d exp 0 11", bus.res_valid, bus.read_pointer); end
    wait_valid(lat);
    n_vec++; if (bus.res_data !== 64'sd2 || bus.res_addr !== 5'd11) begin
      n_err++; $display("FAIL bp_second got data=%0d addr=%0d exp 2 11", bus.res_data, bus.res_addr); end
    tick();
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL bp_done got=%0b exp=1", bus.done); end
    tick();
  endtask

  task automatic test_count_zero_and_busy_start();
    int lat;
    int nvalid;
    start_run(5'd9, 6'd0);
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_count got done=%0b busy=%0b valid=%0b exp 1 0 0", bus.done, bus.busy, bus.res_valid); end
    tick();
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL zero_pulse got done=%0b busy=%0b exp 0 0", bus.done, bus.busy); end
    set_entry(12, 4'd1, 42, 0);
    bus.res_ready = 1'b1;
    start_run(5'd12, 6'd1);
    tick();
    start_run(5'd20, 6'd5);
    tick();
    bus.start = 1'b0;
    wait_valid(lat);
    n_vec++; if (lat !== 1 || bus.res_data !== 64'sd42 || bus.res_addr !== 5'd12) begin
      n_err++; $display("FAIL busy_start got lat=%0d data=%0d addr=%0d exp 1 42 12", lat, bus.res_data, bus.res_addr); end
    tick();
    n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_done got done=%0b busy=%0b exp 1 0", bus.done, bus.busy); end
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.res_valid === 1'b1 || bus.busy === 1'b1) nvalid++;
    end
    n_vec++; if (nvalid !== 0) begin n_err++; $display("FAIL busy_extra got=%0d exp=0", nvalid); end
  endtask

  task automatic test_reset_mid_out();
    int lat;
    set_entry(15, 4'd2, 0, -5);
    bus.res_ready = 1'b0;
    start_run(5'd15, 6'd2);
    wait_valid(lat);
    bus.start = 1'b0;
    n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre got=%0b exp=1", bus.res_valid); end
    reset = 1'b1;
    tick();
    n_vec++; if (bus.res_valid !== 1'b0 || bus.res_data !== 64'sd0 || bus.read_pointer !== 5'd0 ||
                 bus.res_addr !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got valid=%0b data=%0d ptr=%0d addr=%0d busy=%0b done=%0b exp all 0",
                        bus.res_valid, bus.res_data, bus.read_pointer, bus.res_addr, bus.busy, bus.done); end
    reset = 1'b0;
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_nodone got=%0b exp=0", bus.done); end
    bus.res_ready = 1'b1;
    start_run(5'd15, 6'd1);
    wait_valid(lat);
    bus.start = 1'b0;
    n_vec++; if (lat !== 3 || bus.res_data !== -64'sd5 || bus.res_addr !== 5'd15) begin
      n_err++; $display("FAIL rst_rerun got lat=%0d data=%0d addr=%0d exp 3 -5 15", lat, bus.res_data, bus.res_addr); end
    tick();
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rst_rerun_done got=%0b exp=1", bus.done); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) set_entry(i, 4'd0, 0, 0);
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.count      = '0;
    bus.res_ready  = 1'b0;
    test_reset();
    test_add_single();
    test_wrap_arith();
    test_errors();
    test_backpressure();
    test_count_zero_and_busy_start();
    test_reset_mid_out();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_exec_reader.md
Name: instr_exec_reader

Overview:
- Read-side consumer of the instruction register: walks `read_pointer` over a programmed address range and samples the combinational instruction fields.
- Executes each instruction (opcode on operand_a/operand_b) and presents one result per instruction on a valid/ready output channel.
- The testbench writes the register through the load port; this block drains it. It replaces the bench-side read loop and serves as the reference result source for scoreboarding.

Parameters:
- ADDR_W, 5: instruction register address width (32 entries).
- OP_W, 32: signed operand width.
- CNT_W, 6: width of the instruction-count input.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- first_addr  in  ADDR_W  address of first instruction of the run.
- count  in  CNT_W  number of instructions to execute.
- read_pointer  out  ADDR_W  address driven to the instruction register.
- rd_opcode  in  4  opcode field at read_pointer (combinational read, same cycle).
- rd_operand_a  in  OP_W  signed operand_a field at read_pointer.
- rd_operand_b  in  OP_W  signed operand_b field at read_pointer.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  2*OP_W  signed result.
- res_opcode  out  4  opcode of the executed instruction.
- res_addr  out  ADDR_W  address the instruction was read from.
- res_err  out  1  divide/mod by zero or undefined opcode.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; read_pointer, res_*, busy, done and the remaining counter all go to 0.
  - Reset during a run abandons it; no done pulse.
- FSM states: IDLE, FETCH, EXEC, OUT.
- IDLE:
  - start=1 and count!=0: read_pointer<=first_addr, remaining<=count, go to FETCH.
  - start=1 and count==0: done=1 next cycle, stay in IDLE.
- FETCH (1 cycle): register rd_opcode, rd_operand_a, rd_operand_b and read_pointer into internal regs, then go to EXEC.
- EXEC (1 cycle):
  - Compute the result into res_data, res_err, res_opcode, res_addr.
  - res_valid<=1; go to OUT.
- OUT:
  - Hold all res_* stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready: res_valid<=0 and remaining<=remaining-1.
  - If remaining was 1: done=1 for one cycle, go to IDLE.
  - Otherwise read_pointer<=read_pointer+1, wrapping 31->0, and go to FETCH.
- Latency: start to first res_valid = 3 cycles. Throughput is one result per 3 cycles when res_ready is held high.
- start while busy=1 is ignored; the run in progress is unaffected.
- count values above 32 are legal; the pointer wraps and entries are re-read.
- Arithmetic: signed; operands sign-extended to 2*OP_W before the operation; res_err=0 unless stated.
  - opcode 0 ZERO: result 0.
  - opcode 1 PASSA: result a.
  - opcode 2 PASSB: result b.
  - opcode 3 ADD: a+b.
  - opcode 4 SUB: a-b.
  - opcode 5 MULT: a*b (full 64-bit product).
  - opcode 6 DIV: a/b, truncated toward zero.
  - opcode 7 MOD: a%b, sign follows a.
  - DIV or MOD with b==0: res_data=0, res_err=1.
  - opcodes 8..15: res_data=0, res_err=1.
  - -2^31 / -1 = +2^31, with no error.
- res_ready is ignored when res_valid=0.

Test Plan:
- Reset asserted mid-OUT with res_valid=1 -> next edge all outputs 0 and state IDLE. A following start runs normally from first_addr.
- Entry 3 = {ADD, 7, -10}, start first_addr=3 count=1, res_ready=1 -> res_valid 3 cycles after start with res_data=-3, res_addr=3, res_err=0. done pulses the cycle after acceptance.
- Entries 30,31,0 = MULT{-65536,65536}, DIV{-7,2}, MOD{-7,2}, count=3 -> results -4294967296, -3, -1 in order. res_addr sequence 30,31,0 (wrap).
- Entry 5 = DIV{9,0}, then entry 6 = opcode 12 -> both res_data=0, res_err=1.
- Backpressure: hold res_ready=0 for 5 cycles during OUT -> res_valid and res_data stable. read_pointer does not advance until the accepting cycle.
- start with count=0 -> done pulse next cycle, busy stays 0, no res_valid. start pulsed while busy -> ignored; the original run's result count is unchanged.
